// File: rtl/reorder_buffer_nw.sv
// Reorder buffer: in-order allocation, out-of-order completion through NUM_WB
// writeback ports, in-order retirement of up to RETIRE_W entries per cycle, and
// branch-mispredict recovery that squashes every entry younger than the branch.
module reorder_buffer_nw #(
   parameter int DEPTH    = 32,
   parameter int NUM_WB   = 4,
   parameter int RETIRE_W = 2,
   parameter int PREG_W   = 7,
   parameter int PC_W     = 32,
   localparam int TAG_W   = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         alloc_valid,
   output logic                         alloc_ready,
   input  logic [PREG_W-1:0]            alloc_pd_new,
   input  logic [PREG_W-1:0]            alloc_pd_old,
   input  logic                         alloc_has_dest,
   input  logic [PC_W-1:0]              alloc_pc,
   output logic [TAG_W-1:0]             alloc_tag,
   input  logic [NUM_WB-1:0]            wb_valid,
   input  logic [NUM_WB*TAG_W-1:0]      wb_tag,
   input  logic                         br_valid,
   input  logic [TAG_W-1:0]             br_tag,
   input  logic                         br_mispredict,
   output logic                         flush_valid,
   output logic [TAG_W-1:0]             flush_tag,
   output logic [RETIRE_W-1:0]          retire_valid,
   output logic [RETIRE_W*PREG_W-1:0]   retire_pd_old,
   output logic [RETIRE_W-1:0]          retire_has_dest,
   output logic [RETIRE_W*PC_W-1:0]     retire_pc,
   output logic [TAG_W-1:0]             head_tag,
   output logic [TAG_W:0]               count,
   output logic                         full,
   output logic                         empty
);

   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);
   localparam logic [TAG_W:0] ONE_CNT  = (TAG_W+1)'(1);

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   logic [TAG_W:0]      head;
   logic [TAG_W:0]      tail;
   logic [TAG_W-1:0]    head_idx;
   logic [TAG_W-1:0]    br_age;

   // Per-entry status and payload.
   logic [DEPTH-1:0]    ent_valid;
   logic [DEPTH-1:0]    ent_done;
   logic [DEPTH-1:0]    ent_has_dest;
   logic [PREG_W-1:0]   ent_pd_old [DEPTH];
   logic [PC_W-1:0]     ent_pc     [DEPTH];
   // New destination tag is kept with the entry; nothing on the retire path reads it.
   logic [PREG_W-1:0]   ent_pd_new_unused [DEPTH];

   logic                mp;
   logic                alloc_fire;
   logic [TAG_W:0]      ret_cnt;
   logic                ret_run;
   logic [TAG_W-1:0]    ret_idx;
   logic [DEPTH-1:0]    retire_mask;
   logic [DEPTH-1:0]    squash;
   logic [DEPTH-1:0]    set_done;
   logic [DEPTH-1:0]    alloc_mask;
   logic [TAG_W-1:0]    wb_idx;

   // Distance from the head, modulo DEPTH; larger means younger.
   function automatic logic [TAG_W-1:0] age_of(input logic [TAG_W-1:0] t,
                                              input logic [TAG_W-1:0] h);
      return t - h;
   endfunction

   assign head_idx    = head[TAG_W-1:0];
   assign head_tag    = head_idx;
   assign alloc_tag   = tail[TAG_W-1:0];
   assign count       = tail - head;
   assign full        = (count == FULL_CNT);
   assign empty       = (count == '0);
   assign alloc_ready = !full && !flush_valid;
   assign br_age      = age_of(br_tag, head_idx);
   // A mispredict naming an entry that is not in the buffer is ignored.
   assign mp          = br_valid && br_mispredict && ent_valid[br_tag];
   assign alloc_fire  = alloc_valid && alloc_ready && !mp;

   // Retire the leading run of completed entries, never past a mispredicting branch.
   always_comb begin
      retire_valid    = '0;
      retire_pd_old   = '0;
      retire_has_dest = '0;
      retire_pc       = '0;
      retire_mask     = '0;
      ret_cnt         = '0;
      ret_run         = 1'b1;
      ret_idx         = '0;
      for (int unsigned j = 0; j < RETIRE_W; j++) begin
         ret_idx = head_idx + TAG_W'(j);
         if (ret_run && ent_valid[ret_idx] && ent_done[ret_idx] &&
             !(mp && (TAG_W'(j) > br_age))) begin
            retire_valid[j]                   = 1'b1;
            retire_pd_old[j*PREG_W +: PREG_W] = ent_pd_old[ret_idx];
            retire_has_dest[j]                = ent_has_dest[ret_idx];
            retire_pc[j*PC_W +: PC_W]         = ent_pc[ret_idx];
            retire_mask[ret_idx]              = 1'b1;
            ret_cnt                           = ret_cnt + ONE_CNT;
         end else begin
            ret_run = 1'b0;
         end
      end
   end

   // Squash set, completion set and allocation slot for this cycle.
   always_comb begin
      squash     = '0;
      set_done   = '0;
      alloc_mask = '0;
      wb_idx     = '0;
      for (int unsigned t = 0; t < DEPTH; t++) begin
         squash[t] = mp && (age_of(TAG_W'(t), head_idx) > br_age);
      end
      for (int unsigned i = 0; i < NUM_WB; i++) begin
         wb_idx = wb_tag[i*TAG_W +: TAG_W];
         if (wb_valid[i] && !squash[wb_idx]) begin
            set_done[wb_idx] = 1'b1;
         end
      end
      // A resolving branch is also its own completion.
      if (br_valid) begin
         set_done[br_tag] = 1'b1;
      end
      set_done = set_done & ent_valid;
      alloc_mask[alloc_tag] = alloc_fire;
   end

   // Head/tail pointers and the one-cycle flush pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         head        <= '0;
         tail        <= '0;
         flush_valid <= 1'b0;
         flush_tag   <= '0;
      end else begin
         head <= head + ret_cnt;
         // Tail is rebuilt from the pre-retire head so retirement does not shift it.
         if (mp) begin
            tail <= head + {1'b0, br_age} + ONE_CNT;
         end else if (alloc_fire) begin
            tail <= tail + ONE_CNT;
         end
         flush_valid <= mp;
         flush_tag   <= mp ? br_tag : '0;
      end
   end

   // Valid/done bits: retire and squash clear, completion sets, allocation reinitialises.
   always_ff @(posedge clk) begin
      if (reset) begin
         ent_valid <= '0;
         ent_done  <= '0;
      end else begin
         ent_valid <= (ent_valid & ~retire_mask & ~squash) | alloc_mask;
         ent_done  <= (ent_done | set_done) & ~retire_mask & ~squash & ~alloc_mask;
      end
   end

   // Entry payload captured on allocation.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         ent_pd_new_unused[alloc_tag] <= alloc_pd_new;
         ent_pd_old[alloc_tag]        <= alloc_pd_old;
         ent_has_dest[alloc_tag]      <= alloc_has_dest;
         ent_pc[alloc_tag]            <= alloc_pc;
      end
   end

endmodule

// File: tb/tb_reorder_buffer_nw.sv
// Bench for reorder_buffer_nw: directed vector table, hand-written corner
// sequences, and random traffic checked against a queue-based reference model.
module tb_reorder_buffer_nw;

   localparam int DEPTH    = 32;
   localparam int NUM_WB   = 4;
   localparam int RETIRE_W = 2;
   localparam int PREG_W   = 7;
   localparam int PC_W     = 32;
   localparam int TAG_W    = $clog2(DEPTH);

   logic                       clk = 1'b0;
   logic                       reset = 1'b1;
   logic                       alloc_valid;
   logic                       alloc_ready;
   logic [PREG_W-1:0]          alloc_pd_new;
   logic [PREG_W-1:0]          alloc_pd_old;
   logic                       alloc_has_dest;
   logic [PC_W-1:0]            alloc_pc;
   logic [TAG_W-1:0]           alloc_tag;
   logic [NUM_WB-1:0]          wb_valid;
   logic [NUM_WB*TAG_W-1:0]    wb_tag;
   logic                       br_valid;
   logic [TAG_W-1:0]           br_tag;
   logic                       br_mispredict;
   logic                       flush_valid;
   logic [TAG_W-1:0]           flush_tag;
   logic [RETIRE_W-1:0]        retire_valid;
   logic [RETIRE_W*PREG_W-1:0] retire_pd_old;
   logic [RETIRE_W-1:0]        retire_has_dest;
   logic [RETIRE_W*PC_W-1:0]   retire_pc;
   logic [TAG_W-1:0]           head_tag;
   logic [TAG_W:0]             count;
   logic                       full;
   logic                       empty;

   reorder_buffer_nw #(
      .DEPTH(DEPTH), .NUM_WB(NUM_WB), .RETIRE_W(RETIRE_W), .PREG_W(PREG_W), .PC_W(PC_W)
   ) dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old),
      .alloc_has_dest(alloc_has_dest), .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag),
      .br_valid(br_valid), .br_tag(br_tag), .br_mispredict(br_mispredict),
      .flush_valid(flush_valid), .flush_tag(flush_tag),
      .retire_valid(retire_valid), .retire_pd_old(retire_pd_old),
      .retire_has_dest(retire_has_dest), .retire_pc(retire_pc),
      .head_tag(head_tag), .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: queue of live entries, oldest first
   typedef struct {
      bit                done;
      logic [PREG_W-1:0] pd_old;
      logic              has_dest;
      logic [PC_W-1:0]   pc;
   } ment_t;

   ment_t mq[$];
   int    m_head      = 0;
   bit    m_flush     = 0;
   int    m_flush_tag = 0;
   // per-cycle predictions
   bit    e_ready;
   bit    e_mp;
   int    e_p;
   int    e_k;

   function automatic int posof(input int t);
      return (t - m_head + DEPTH) % DEPTH;
   endfunction

   function automatic logic [TAG_W-1:0] pick_tag();
      return TAG_W'((m_head + int'($urandom_range(0, mq.size()))) % DEPTH);
   endfunction

   task automatic model_eval();
      e_ready = (mq.size() < DEPTH) && !m_flush;
      e_mp = 0;
      e_p  = 0;
      if (br_valid && br_mispredict) begin
         e_p  = posof(int'(br_tag));
         e_mp = (e_p < mq.size());
      end
      e_k = 0;
      for (int j = 0; j < RETIRE_W; j++) begin
         if (e_k == j && j < mq.size() && mq[j].done && (!e_mp || j <= e_p)) e_k++;
      end
   endtask

   task automatic model_compare();
      chk("count", count, mq.size());
      chk("full", full, mq.size() == DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("alloc_ready", alloc_ready, e_ready);
      chk("alloc_tag", alloc_tag, (m_head + mq.size()) % DEPTH);
      chk("head_tag", head_tag, m_head);
      chk("flush_valid", flush_valid, m_flush);
      chk("flush_tag", flush_tag, m_flush_tag);
      chk("retire_valid", retire_valid, (1 << e_k) - 1);
      for (int j = 0; j < e_k; j++) begin
         chk("retire_pd_old", retire_pd_old[j*PREG_W +: PREG_W], mq[j].pd_old);
         chk("retire_has_dest", retire_has_dest[j], mq[j].has_dest);
         chk("retire_pc", retire_pc[j*PC_W +: PC_W], mq[j].pc);
      end
   endtask

   task automatic model_update();
      bit    fire;
      int    pos;
      ment_t e;
      if (reset) begin
         mq.delete();
         m_head      = 0;
         m_flush     = 0;
         m_flush_tag = 0;
         return;
      end
      fire = alloc_valid && e_ready && !e_mp;
      for (int i = 0; i < NUM_WB; i++) begin
         if (wb_valid[i]) begin
            pos = posof(int'(wb_tag[i*TAG_W +: TAG_W]));
            if (pos < mq.size() && !(e_mp && pos > e_p)) mq[pos].done = 1;
         end
      end
      if (br_valid) begin
         pos = posof(int'(br_tag));
         if (pos < mq.size()) mq[pos].done = 1;
      end
      if (e_mp) while (mq.size() > e_p + 1) void'(mq.pop_back());
      repeat (e_k) void'(mq.pop_front());
      m_head = (m_head + e_k) % DEPTH;
      if (fire) begin
         e.done = 0; e.pd_old = alloc_pd_old; e.has_dest = alloc_has_dest; e.pc = alloc_pc;
         mq.push_back(e);
      end
      m_flush     = e_mp;
      m_flush_tag = e_mp ? int'(br_tag) : 0;
   endtask

   // One clock: check outputs mid-cycle, let the edge happen, advance the model.
   task automatic step();
      @(negedge clk);
      model_eval();
      model_compare();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      alloc_valid   = 1'b0;
      wb_valid      = '0;
      wb_tag        = '0;
      br_valid      = 1'b0;
      br_tag        = '0;
      br_mispredict = 1'b0;
   endtask

   task automatic drive_alloc();
      alloc_valid    = 1'b1;
      alloc_pd_new   = PREG_W'($urandom);
      alloc_pd_old   = PREG_W'($urandom);
      alloc_has_dest = 1'($urandom);
      alloc_pc       = PC_W'($urandom);
   endtask

   task automatic check_reset_values();
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_alloc_tag", alloc_tag, 0);
      chk("rst_flush_valid", flush_valid, 0);
      chk("rst_flush_tag", flush_tag, 0);
      chk("rst_retire_valid", retire_valid, 0);
      chk("rst_head_tag", head_tag, 0);
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check_reset_values();
   endtask

   // ---------------- directed vector table (out-of-order completion)
   typedef struct {
      logic                    alloc_v;
      logic [NUM_WB-1:0]       wb_v;
      logic [NUM_WB*TAG_W-1:0] wb_t;
      logic [TAG_W-1:0]        exp_alloc_tag;
      logic [TAG_W:0]          exp_count;
      logic [RETIRE_W-1:0]     exp_rv;
      logic [TAG_W-1:0]        exp_head;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      alloc_pd_new = '0; alloc_pd_old = '0; alloc_has_dest = 1'b0; alloc_pc = '0;
      idle();
      @(posedge clk);
      #1;
      do_reset();

      vecs[0] = '{1'b1, 4'b0000, 20'd0, 5'd0, 6'd0, 2'b00, 5'd0};
      vecs[1] = '{1'b1, 4'b0000, 20'd0, 5'd1, 6'd1, 2'b00, 5'd0};
      vecs[2] = '{1'b1, 4'b0000, 20'd0, 5'd2, 6'd2, 2'b00, 5'd0};
      vecs[3] = '{1'b1, 4'b0000, 20'd0, 5'd3, 6'd3, 2'b00, 5'd0};
      vecs[4] = '{1'b0, 4'b0111, {5'd0, 5'd1, 5'd2, 5'd3}, 5'd4, 6'd4, 2'b00, 5'd0};
      vecs[5] = '{1'b0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, 5'd4, 6'd4, 2'b00, 5'd0};
      vecs[6] = '{1'b0, 4'b0000, 20'd0, 5'd4, 6'd4, 2'b11, 5'd0};
      vecs[7] = '{1'b0, 4'b0000, 20'd0, 5'd4, 6'd2, 2'b11, 5'd2};
      vecs[8] = '{1'b0, 4'b0000, 20'd0, 5'd4, 6'd0, 2'b00, 5'd4};
      for (int v = 0; v < 9; v++) begin
         idle();
         if (vecs[v].alloc_v) drive_alloc();
         wb_valid = vecs[v].wb_v;
         wb_tag   = vecs[v].wb_t;
         #1;
         chk("vec_alloc_tag", alloc_tag, vecs[v].exp_alloc_tag);
         chk("vec_count", count, vecs[v].exp_count);
         chk("vec_retire_valid", retire_valid, vecs[v].exp_rv);
         chk("vec_head_tag", head_tag, vecs[v].exp_head);
         step();
      end

      // Fill to capacity, then a 33rd request must be refused.
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         idle(); drive_alloc(); #1;
         chk("fill_alloc_tag", alloc_tag, i);
         chk("fill_alloc_ready", alloc_ready, 1);
         step();
      end
      idle(); drive_alloc(); #1;
      chk("fill_full", full, 1);
      chk("fill_count", count, DEPTH);
      chk("fill_ready_low", alloc_ready, 0);
      step();
      idle(); #1;
      chk("fill_count_hold", count, DEPTH);

      // Mispredict on tag 4 with ten entries live.
      do_reset();
      for (int i = 0; i < 10; i++) begin idle(); drive_alloc(); step(); end
      idle(); br_valid = 1'b1; br_tag = 5'd4; br_mispredict = 1'b1; drive_alloc();
      step();
      idle(); wb_valid[0] = 1'b1; wb_tag[0 +: TAG_W] = 5'd7; #1;
      chk("mp_count", count, 5);
      chk("mp_alloc_tag", alloc_tag, 5);
      chk("mp_flush_valid", flush_valid, 1);
      chk("mp_flush_tag", flush_tag, 4);
      chk("mp_ready_low", alloc_ready, 0);
      step();
      idle(); #1;
      chk("mp_flush_one_cycle", flush_valid, 0);
      chk("mp_ready_back", alloc_ready, 1);
      chk("mp_next_alloc_tag", alloc_tag, 5);
      for (int i = 0; i < 3; i++) begin idle(); drive_alloc(); step(); end
      idle();
      for (int i = 0; i < 4; i++) begin wb_valid[i] = 1'b1; wb_tag[i*TAG_W +: TAG_W] = TAG_W'(i); end
      step();
      idle();
      for (int i = 0; i < 3; i++) begin wb_valid[i] = 1'b1; wb_tag[i*TAG_W +: TAG_W] = TAG_W'(4 + i); end
      step();
      idle();
      repeat (6) step();
      chk("mp_tag7_not_done_count", count, 1);
      chk("mp_tag7_not_done_head", head_tag, 7);

      // Wrap-around: drain to head=30, allocate across the wrap, mispredict on 31.
      do_reset();
      for (int i = 0; i < 30; i++) begin idle(); drive_alloc(); step(); end
      for (int g = 0; g < 8; g++) begin
         idle();
         for (int i = 0; i < NUM_WB; i++) begin
            wb_valid[i] = 1'b1; wb_tag[i*TAG_W +: TAG_W] = TAG_W'(4*g + i);
         end
         step();
      end
      idle();
      for (int guard = 0; guard < 60 && !(empty === 1'b1 && head_tag == 5'd30); guard++) step();
      chk("wrap_drain_head", head_tag, 30);
      chk("wrap_drain_count", count, 0);
      for (int i = 0; i < 4; i++) begin
         idle(); drive_alloc(); #1;
         chk("wrap_alloc_tag", alloc_tag, (30 + i) % DEPTH);
         step();
      end
      idle(); br_valid = 1'b1; br_tag = 5'd31; br_mispredict = 1'b1;
      step();
      idle(); #1;
      chk("wrap_mp_count", count, 2);
      chk("wrap_mp_alloc_tag", alloc_tag, 0);
      chk("wrap_mp_head", head_tag, 30);

      // Retire and mispredict on the oldest entry in the same cycle.
      do_reset();
      for (int i = 0; i < 2; i++) begin idle(); drive_alloc(); step(); end
      idle();
      wb_valid = 4'b0011; wb_tag[0 +: TAG_W] = 5'd0; wb_tag[TAG_W +: TAG_W] = 5'd1;
      step();
      idle(); br_valid = 1'b1; br_tag = 5'd0; br_mispredict = 1'b1; #1;
      chk("sim_retire_valid", retire_valid, 2'b01);
      step();
      idle(); #1;
      chk("sim_head", head_tag, 1);
      chk("sim_count", count, 0);
      chk("sim_empty", empty, 1);
      chk("sim_alloc_tag", alloc_tag, 1);

      // Reset asserted during the flush cycle.
      do_reset();
      for (int i = 0; i < 3; i++) begin idle(); drive_alloc(); step(); end
      idle(); br_valid = 1'b1; br_tag = 5'd0; br_mispredict = 1'b1;
      step();
      idle(); reset = 1'b1; #1;
      chk("rmf_flush_seen", flush_valid, 1);
      step();
      reset = 1'b0; #1;
      check_reset_values();

      // Random traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         idle();
         reset = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 9) < 7) drive_alloc();
         for (int i = 0; i < NUM_WB; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               wb_valid[i] = 1'b1;
               wb_tag[i*TAG_W +: TAG_W] = pick_tag();
            end
         end
         if ($urandom_range(0, 9) == 0) begin
            br_valid      = 1'b1;
            br_tag        = pick_tag();
            br_mispredict = ($urandom_range(0, 2) == 0);
         end
         step();
      end
      reset = 1'b0;
      idle();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reorder_buffer_nw.md
REORDER_BUFFER_NW -- requirements
Module: reorder_buffer_nw

Interface
REQ-001 SHALL have parameter DEPTH, default 32, entry count (power of two, >=4); TAG_W = $clog2(DEPTH).
REQ-002 SHALL have parameter NUM_WB, default 4, number of completion (writeback) ports.
REQ-003 SHALL have parameter RETIRE_W, default 2, maximum entries retired per cycle (1..4).
REQ-004 SHALL have parameter PREG_W, default 7, physical register tag width; PC_W, default 32.
REQ-005 SHALL have ports: clk input 1 clock; reset input 1 synchronous active-high reset.
REQ-006 SHALL have ports: alloc_valid in 1; alloc_ready out 1; alloc_pd_new in PREG_W; alloc_pd_old in PREG_W; alloc_has_dest in 1; alloc_pc in PC_W; alloc_tag out TAG_W (tag granted this cycle).
REQ-007 SHALL have ports: wb_valid in NUM_WB; wb_tag in NUM_WB*TAG_W (port i at bits [i*TAG_W +: TAG_W]).
REQ-008 SHALL have ports: br_valid in 1; br_tag in TAG_W; br_mispredict in 1.
REQ-009 SHALL have ports: flush_valid out 1; flush_tag out TAG_W (surviving branch tag).
REQ-010 SHALL have ports: retire_valid out RETIRE_W; retire_pd_old out RETIRE_W*PREG_W; retire_has_dest out RETIRE_W; retire_pc out RETIRE_W*PC_W; slot 0 oldest.
REQ-011 SHALL have ports: head_tag out TAG_W; count out TAG_W+1; full out 1; empty out 1.

Function
REQ-012 SHALL hold head and tail pointers of TAG_W+1 bits (MSB = wrap); count = tail-head; full = (count==DEPTH); empty = (count==0).
REQ-013 SHALL drive alloc_ready = !full && !flush_valid, computed from registered state only (no same-cycle retire bypass).
REQ-014 SHALL drive alloc_tag = tail[TAG_W-1:0] combinationally; on alloc_valid && alloc_ready write entry {valid=1, done=0, pd_new, pd_old, has_dest, pc} and increment tail.
REQ-015 SHALL set done for entry wb_tag[i] at next edge when wb_valid[i] and entry is valid and not squashed this cycle; writebacks to invalid entries are ignored; duplicate tags across ports are legal.
REQ-016 SHALL treat br_valid as a completion of entry br_tag (sets done) regardless of br_mispredict.
REQ-017 SHALL define age(t) = (t - head) mod DEPTH; entry A is younger than B iff age(A) > age(B).
REQ-018 SHALL, on br_valid && br_mispredict, clear valid of every entry younger than br_tag and set tail = head + age(br_tag) + 1 (with wrap bit) at the next edge.
REQ-019 SHALL suppress allocation in the mispredict cycle and ignore writebacks to tags younger than br_tag in that cycle.
REQ-020 SHALL assert flush_valid for exactly one cycle, the cycle after the mispredict edge, with flush_tag = br_tag; alloc_ready is low while flush_valid is high.
REQ-021 SHALL retire, each cycle, the longest run of k <= RETIRE_W consecutive valid && done entries starting at head; retire_valid[j]=1 for j<k, 0 otherwise; stop at first not-done entry.
REQ-022 SHALL drive retire outputs combinationally from registered entry state; head advances by k and retired entries are cleared at the next edge.
REQ-023 SHALL allow retire and mispredict in the same cycle; retirement is limited to entries with age <= age(br_tag), and the tail update of REQ-018 is applied independently of head movement.
REQ-024 SHALL allow retire, allocation and writeback in the same cycle; allocation into a slot freed that same cycle is not permitted (REQ-013).
REQ-025 SHALL handle pointer wrap-around: tag DEPTH-1 is followed by tag 0; full and empty distinguished only by wrap bit.
REQ-026 SHALL drive head_tag = head[TAG_W-1:0]; a mispredict with br_tag not valid in the buffer is ignored.

Reset
REQ-027 SHALL on reset clear head, tail, all valid/done bits; outputs: alloc_ready=1, alloc_tag=0, flush_valid=0, flush_tag=0, retire_valid=0, head_tag=0, count=0, full=0, empty=1.
REQ-028 SHALL give reset priority over all other inputs, including mid-flush and mid-retire.

Verification
REQ-029 Fill: DEPTH=32, 32 back-to-back allocs, no wb -> tags 0..31, full=1, count=32, alloc_ready=0 on 33rd.
REQ-030 Out-of-order wb: alloc tags 0..3, wb tags 3,2,1 on ports 0..2 same cycle, then tag 0 -> no retire until tag 0 done; next cycle retire_valid=2'b11 (0,1), following cycle 2'b11 (2,3).
REQ-031 Mispredict: alloc 0..9, br_valid with mispredict on tag 4 -> next cycle count=5, tail=5, flush_valid=1 flush_tag=4 for one cycle; later wb to tag 7 ignored; next alloc_tag=5.
REQ-032 Wrap: head=30 tail=30, alloc 4 -> tags 30,31,0,1; mispredict on 31 -> tail=0 (wrap bit set), count=2.
REQ-033 Simultaneous: tags 0,1 done, mispredict on tag 0 same cycle -> retire_valid=2'b01 only; head=1, tail=1, empty=1.
REQ-034 Reset mid-flush: assert reset in flush_valid cycle -> next cycle all REQ-027 values, flush_valid=0.
